// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS execution stage: ALU operation codes and
// R-type funct field encodings.
package mips_alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOR = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/mips_alu_unit_if.sv
// Operand/result bundle of the execution-stage arithmetic block; the
// master side drives operands and control, the slave side returns results.
interface mips_alu_unit_if;

    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        flag_we;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero;
    logic [31:0] add_sum;
    logic        n_flag;
    logic        z_flag;
    logic        v_flag;

    modport master (
        output aluop, funct, a, b, add_a, add_b, flag_we,
        input  gout, result, zero, add_sum, n_flag, z_flag, v_flag
    );

    modport slave (
        input  aluop, funct, a, b, add_a, add_b, flag_we,
        output gout, result, zero, add_sum, n_flag, z_flag, v_flag
    );

endinterface

// File: rtl/mips_alu_unit_add32.sv
// General 32-bit wrap-around adder, shared by PC+4 and branch-target paths.
module add32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/mips_alu_unit.sv
// Execution-stage arithmetic: ALU-control decode, 32-bit ALU with zero
// detect, general adder, and a registered N/Z/V status-flag triple.
module mips_alu_unit
    import mips_alu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mips_alu_unit_if.slave bus
);

    alu_op_e     op_s;
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [31:0] result_s;
    logic        zero_s;
    logic        ovf_s;
    logic [31:0] add_sum_s;
    logic        n_q, z_q, v_q;
    logic        n_d, z_d, v_d;

    // aluop0 dominates aluop1, so 11 decodes as SUB like 01
    always_comb begin
        op_s = ALU_ADD;
        if (bus.aluop[0]) begin
            op_s = ALU_SUB;
        end else if (bus.aluop[1]) begin
            case (bus.funct)
                FUNCT_ADD: op_s = ALU_ADD;
                FUNCT_SUB: op_s = ALU_SUB;
                FUNCT_AND: op_s = ALU_AND;
                FUNCT_OR:  op_s = ALU_OR;
                FUNCT_NOR: op_s = ALU_NOR;
                FUNCT_SLT: op_s = ALU_SLT;
                default:   op_s = ALU_ADD;
            endcase
        end
    end

    assign sum_s  = bus.a + bus.b;
    assign diff_s = bus.a - bus.b;

    always_comb begin
        result_s = '0;
        ovf_s    = 1'b0;
        case (op_s)
            ALU_AND: result_s = bus.a & bus.b;
            ALU_OR:  result_s = bus.a | bus.b;
            ALU_NOR: result_s = ~(bus.a | bus.b);
            ALU_ADD: begin
                result_s = sum_s;
                ovf_s    = (bus.a[31] == bus.b[31]) && (sum_s[31] != bus.a[31]);
            end
            ALU_SUB: begin
                result_s = diff_s;
                ovf_s    = (bus.a[31] != bus.b[31]) && (diff_s[31] != bus.a[31]);
            end
            // true signed compare, not the sign of a-b, so overflow cannot flip it
            ALU_SLT: result_s = {31'd0, $signed(bus.a) < $signed(bus.b)};
            default: result_s = '0;
        endcase
    end

    assign zero_s = ~|result_s;

    add32 u_add32 (
        .a_i   (bus.add_a),
        .b_i   (bus.add_b),
        .sum_o (add_sum_s)
    );

    always_comb begin
        n_d = n_q;
        z_d = z_q;
        v_d = v_q;
        if (bus.flag_we) begin
            n_d = result_s[31];
            z_d = zero_s;
            v_d = ovf_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            n_q <= n_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    assign bus.gout    = op_s;
    assign bus.result  = result_s;
    assign bus.zero    = zero_s;
    assign bus.add_sum = add_sum_s;
    assign bus.n_flag  = n_q;
    assign bus.z_flag  = z_q;
    assign bus.v_flag  = v_q;

endmodule

// File: tb/tb_mips_alu_unit.sv
// Scoreboard bench for mips_alu_unit: expected results are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_mips_alu_unit;

    typedef struct {
        string       tag;
        logic [2:0]  gout;
        logic [31:0] result;
        logic        zero;
        logic [31:0] sum;
    } alu_exp_t;

    typedef struct {
        string      tag;
        logic [2:0] nzv;
    } flag_exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    alu_exp_t  alu_q[$];
    flag_exp_t flag_q[$];

    mips_alu_unit_if bus ();

    mips_alu_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [2:0] m_dec(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 3'b010;
        if (op[0]) return 3'b110;
        case (fn)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h27: return 3'b011;
            6'h2A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] g, input logic [31:0] av, input logic [31:0] bv);
        case (g)
            3'b000: return av & bv;
            3'b001: return av | bv;
            3'b010: return av + bv;
            3'b110: return av + ~bv + 32'd1;
            3'b011: return ~av & ~bv;
            3'b111: return (av[31] != bv[31]) ? {31'd0, av[31]} : {31'd0, av < bv};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_ovf(input logic [2:0] g, input logic [31:0] av, input logic [31:0] bv);
        logic [32:0] w;
        if (g == 3'b010) begin
            w = {av[31], av} + {bv[31], bv};
            return w[32] != w[31];
        end
        if (g == 3'b110) begin
            w = {av[31], av} - {bv[31], bv};
            return w[32] != w[31];
        end
        return 1'b0;
    endfunction

    task automatic observe_alu();
        alu_exp_t e;
        if (alu_q.size() == 0) begin
            check_eq("alu_queue_empty", 32'd1, 32'd0);
            return;
        end
        e = alu_q.pop_front();
        check_eq({e.tag, ".gout"},   {29'd0, bus.gout}, {29'd0, e.gout});
        check_eq({e.tag, ".result"}, bus.result, e.result);
        check_eq({e.tag, ".zero"},   {31'd0, bus.zero}, {31'd0, e.zero});
        check_eq({e.tag, ".sum"},    bus.add_sum, e.sum);
    endtask

    task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] aa, input logic [31:0] ab,
                         input logic [2:0] eg, input logic [31:0] er, input logic [31:0] es);
        alu_exp_t e;
        bus.aluop = op;
        bus.funct = fn;
        bus.a     = av;
        bus.b     = bv;
        bus.add_a = aa;
        bus.add_b = ab;
        e.tag = tag; e.gout = eg; e.result = er; e.zero = (er == 32'd0); e.sum = es;
        alu_q.push_back(e);
        #1;
        observe_alu();
    endtask

    task automatic observe_flags();
        flag_exp_t f;
        if (flag_q.size() == 0) begin
            check_eq("flag_queue_empty", 32'd1, 32'd0);
            return;
        end
        f = flag_q.pop_front();
        check_eq({f.tag, ".nzv"}, {29'd0, bus.n_flag, bus.z_flag, bus.v_flag}, {29'd0, f.nzv});
    endtask

    // Drives flag_we for one rising edge with the currently applied operands.
    task automatic capture(input string tag, input logic we, input logic [2:0] exp_nzv);
        flag_exp_t f;
        bus.flag_we = we;
        f.tag = tag; f.nzv = exp_nzv;
        flag_q.push_back(f);
        @(posedge clk);
        #1;
        bus.flag_we = 1'b0;
        observe_flags();
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  fns [7];
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] av, bv, aa, ab, er;
        logic [2:0]  g;
        logic        we;
        logic [2:0]  cur_nzv;

        n_checks = 0;
        n_pass   = 0;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;
        fns[4] = 6'h27; fns[5] = 6'h2A; fns[6] = 6'h00;

        reset = 1'b1;
        bus.aluop = 2'b00; bus.funct = '0; bus.a = '0; bus.b = '0;
        bus.add_a = '0; bus.add_b = '0; bus.flag_we = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_flags", {29'd0, bus.n_flag, bus.z_flag, bus.v_flag}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_flags", {29'd0, bus.n_flag, bus.z_flag, bus.v_flag}, 32'd0);

        // decode sweep
        apply("dec_00",    2'b00, 6'h3F, 32'd1, 32'd1, 32'd0, 32'd0, 3'b010, 32'd2, 32'd0);
        apply("dec_01",    2'b01, 6'h20, 32'd1, 32'd1, 32'd0, 32'd0, 3'b110, 32'd0, 32'd0);
        apply("dec_11",    2'b11, 6'h25, 32'd3, 32'd1, 32'd0, 32'd0, 3'b110, 32'd2, 32'd0);
        apply("dec_f20",   2'b10, 6'h20, 32'd3, 32'd4, 32'd0, 32'd0, 3'b010, 32'd7, 32'd0);
        apply("dec_f22",   2'b10, 6'h22, 32'd3, 32'd4, 32'd0, 32'd0, 3'b110, 32'hFFFFFFFF, 32'd0);
        apply("dec_f3F",   2'b10, 6'h3F, 32'd3, 32'd4, 32'd0, 32'd0, 3'b010, 32'd7, 32'd0);

        // logic ops
        apply("and",       2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 3'b000, 32'h00F000F0, 32'd0);
        apply("or",        2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 3'b001, 32'hFFF0FFF0, 32'd0);
        apply("nor",       2'b10, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 3'b011, 32'h000F000F, 32'd0);

        // signed compare, including the case where a-b overflows
        apply("slt_m1_1",  2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd0, 3'b111, 32'd1, 32'd0);
        apply("slt_1_m1",  2'b10, 6'h2A, 32'd1,        32'hFFFFFFFF, 32'd0, 32'd0, 3'b111, 32'd0, 32'd0);
        apply("slt_min",   2'b10, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0, 3'b111, 32'd1, 32'd0);

        // adder, including wrap-around
        apply("add_neg",   2'b00, 6'h00, 32'd0, 32'd0, 32'h00000004, 32'hFFFFFFF8, 3'b010, 32'd0, 32'hFFFFFFFC);
        apply("add_wrap",  2'b00, 6'h00, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'd0, 32'h00000000);

        // arithmetic with flag capture
        apply("add_ovf",   2'b00, 6'h00, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 3'b010, 32'h80000000, 32'd0);
        capture("flags_add_ovf", 1'b1, 3'b101);
        apply("sub_eq",    2'b01, 6'h00, 32'd5, 32'd5, 32'd0, 32'd0, 3'b110, 32'd0, 32'd0);
        capture("flags_sub_eq", 1'b1, 3'b010);
        apply("sub_ovf",   2'b01, 6'h00, 32'h80000000, 32'd1, 32'd0, 32'd0, 3'b110, 32'h7FFFFFFF, 32'd0);
        capture("flags_hold", 1'b0, 3'b010);
        capture("flags_sub_ovf", 1'b1, 3'b001);

        // reset mid-cycle clears flags at once and wins over a coinciding capture
        apply("add_ovf2",  2'b00, 6'h00, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 3'b010, 32'h80000000, 32'd0);
        capture("flags_set_nv", 1'b1, 3'b101);
        #2;
        reset = 1'b1;
        #1;
        check_eq("reset_async", {29'd0, bus.n_flag, bus.z_flag, bus.v_flag}, 32'd0);
        @(negedge clk);
        capture("reset_beats_we", 1'b1, 3'b000);
        reset = 1'b0;
        capture("no_we_after_reset", 1'b0, 3'b000);
        capture("first_capture", 1'b1, 3'b101);

        // randomized sweep against the reference model
        cur_nzv = 3'b101;
        for (int unsigned i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = fns[$urandom_range(0, 6)];
            if (fn == 6'h00) fn = 6'($urandom);
            av = $urandom; bv = $urandom; aa = $urandom; ab = $urandom;
            if (i % 8 == 0) bv = av;
            g  = m_dec(op, fn);
            er = m_alu(g, av, bv);
            apply($sformatf("rnd%0d", i), op, fn, av, bv, aa, ab, g, er, aa + ab);
            we = 1'($urandom_range(0, 1));
            if (we) cur_nzv = {er[31], er == 32'd0, m_ovf(g, av, bv)};
            capture($sformatf("rnd%0d_flags", i), we, cur_nzv);
        end

        check_eq("queues_drained", alu_q.size() + flag_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
